control_pipe: RTL

CONTROL_PIPE -- requirements
Module: control_pipe

---
 rtl/control_pipe.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/control_pipe.sv
// Three-stage control-bundle pipeline (ID/EX -> EX/MEM -> MEM/WB) with hold, flush and stall bubbles.
// Optional load-use hazard detection: define CONTROL_PIPE_LOADUSE_EN.
`ifndef OP_RTYPE
`define OP_RTYPE 6'h00
`endif
`ifndef OP_JUMP
`define OP_JUMP  6'h02
`endif
`ifndef OP_BEQ
`define OP_BEQ   6'h04
`endif
`ifndef OP_LDB
`define OP_LDB   6'h20
`endif
`ifndef OP_LDW
`define OP_LDW   6'h23
`endif
`ifndef OP_STB
`define OP_STB   6'h28
`endif
`ifndef OP_STW
`define OP_STW   6'h2B
`endif

module control_pipe #(
   parameter int OPCODE_W = 6,
   parameter int REG_W    = 5,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid_i,
   input  logic [OPCODE_W-1:0] id_opcode_i,
   input  logic [REG_W-1:0]    id_rs_i,
   input  logic [REG_W-1:0]    id_rt_i,
   input  logic [REG_W-1:0]    id_dest_i,
   input  logic                stall_in_i,
   input  logic                hold_i,
   input  logic                flush_i,
   output logic                ex_alusrc_o,
   output logic                ex_branch_o,
   output logic                ex_jump_o,
   output logic                mem_memwrite_o,
   output logic                mem_memread_o,
   output logic                mem_byteword_o,
   output logic                wb_regwrite_o,
   output logic                wb_memtoreg_o,
   output logic [REG_W-1:0]    wb_dest_o,
   output logic                stall_out_o,
   output logic                illegal_op_o,
   output logic [CNT_W-1:0]    bubble_cnt_o
);

   typedef struct packed {
      logic             regwrite;
      logic             memtoreg;
      logic             branch;
      logic             jump;
      logic             memwrite;
      logic             memread;
      logic             byteword;  // 1 = word access, 0 = byte access
      logic             alusrc;    // 1 = second ALU operand from register file
      logic [REG_W-1:0] dest;
   } ctrl_t;

   ctrl_t            dec;
   logic             dec_known;
   logic             rt_used;
   logic             stall_any;

   ctrl_t            idex_q, idex_d;
   ctrl_t            exmem_q, exmem_d;
   ctrl_t            memwb_q, memwb_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Fields not listed for an opcode stay at the zero default.
   always_comb begin
      dec       = '0;
      dec_known = 1'b1;
      rt_used   = 1'b0;
      case (id_opcode_i)
         OPCODE_W'(`OP_RTYPE): begin
            dec.regwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.dest     = id_dest_i;
            rt_used      = 1'b1;
         end
         OPCODE_W'(`OP_LDB): begin
            dec.regwrite = 1'b1;
            dec.memtoreg = 1'b1;
            dec.memread  = 1'b1;
            dec.dest     = id_dest_i;
         end
         OPCODE_W'(`OP_LDW): begin
            dec.regwrite = 1'b1;
            dec.memtoreg = 1'b1;
            dec.memread  = 1'b1;
            dec.byteword = 1'b1;
            dec.dest     = id_dest_i;
         end
         OPCODE_W'(`OP_STB): begin
            dec.memwrite = 1'b1;
            rt_used      = 1'b1;
         end
         OPCODE_W'(`OP_STW): begin
            dec.memwrite = 1'b1;
            dec.byteword = 1'b1;
            rt_used      = 1'b1;
         end
         OPCODE_W'(`OP_BEQ): begin
            dec.branch = 1'b1;
            dec.alusrc = 1'b1;
            rt_used    = 1'b1;
         end
         OPCODE_W'(`OP_JUMP): dec.jump = 1'b1;
         default: dec_known = 1'b0;
      endcase
   end

`ifdef CONTROL_PIPE_LOADUSE_EN
   assign stall_out_o = id_valid_i && idex_q.memread && (idex_q.dest != '0) &&
                        ((idex_q.dest == id_rs_i) || (rt_used && (idex_q.dest == id_rt_i)));
`else
   logic unused_ok;
   assign unused_ok   = ^{id_rs_i, id_rt_i, rt_used};
   assign stall_out_o = 1'b0;
`endif

   assign stall_any = stall_in_i | stall_out_o;

   // hold freezes everything; otherwise flush beats stall beats decode.
   always_comb begin
      idex_d    = idex_q;
      exmem_d   = exmem_q;
      memwb_d   = memwb_q;
      illegal_d = illegal_q;
      cnt_d     = cnt_q;
      if (!hold_i) begin
         memwb_d   = exmem_q;
         illegal_d = 1'b0;
         if (flush_i) begin
            idex_d  = '0;
            exmem_d = '0;
         end else begin
            exmem_d = idex_q;
            idex_d  = '0;
            if (!stall_any && id_valid_i) begin
               if (dec_known) idex_d = dec;
               else           illegal_d = 1'b1;
            end
         end
         if ((flush_i || stall_any) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_q    <= '0;
         exmem_q   <= '0;
         memwb_q   <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         idex_q    <= idex_d;
         exmem_q   <= exmem_d;
         memwb_q   <= memwb_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign ex_alusrc_o    = idex_q.alusrc;
   assign ex_branch_o    = idex_q.branch;
   assign ex_jump_o      = idex_q.jump;
   assign mem_memwrite_o = exmem_q.memwrite;
   assign mem_memread_o  = exmem_q.memread;
   assign mem_byteword_o = exmem_q.byteword;
   assign wb_regwrite_o  = memwb_q.regwrite;
   assign wb_memtoreg_o  = memwb_q.memtoreg;
   assign wb_dest_o      = memwb_q.dest;
   assign illegal_op_o   = illegal_q;
   assign bubble_cnt_o   = cnt_q;

endmodule
